// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised modulus counter: mode encodings and
// the next-value/boundary rule used by the step calculator.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Returns {boundary, next}. All arithmetic is one bit wider than the operands
  // so count+STEP and MAX_VAL+1 never alias, even at WIDTH=32.
  function automatic logic [32:0] next_count(
    input logic [31:0] cur,
    input logic [31:0] step,
    input logic [31:0] max,
    input logic        up,
    input logic        sat
  );
    logic [32:0] w_sum;
    logic [32:0] w_mod;
    w_mod      = {1'b0, max} + 33'd1;
    w_sum      = '0;
    next_count = '0;
    if (up) begin
      w_sum = {1'b0, cur} + {1'b0, step};
      if (w_sum <= {1'b0, max}) begin
        next_count = {1'b0, w_sum[31:0]};
      end else if (sat) begin
        next_count = {1'b1, max};
      end else begin
        w_sum      = w_sum - w_mod;
        next_count = {1'b1, w_sum[31:0]};
      end
    end else begin
      if (cur >= step) begin
        next_count = {1'b0, cur - step};
      end else if (sat) begin
        next_count = {1'b1, 32'd0};
      end else begin
        w_sum      = {1'b0, cur} + w_mod - {1'b0, step};
        next_count = {1'b1, w_sum[31:0]};
      end
    end
  endfunction

endpackage

// File: rtl/mod_step_calc.sv
// Combinational step calculator: next count value and boundary-event indication
// for the current count and direction.
module mod_step_calc
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter logic [31:0] MAX_VAL  = 32'd15,
  parameter logic [31:0] STEP     = 32'd1,
  parameter logic        SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_next,
  output logic             o_boundary
);

  logic [32:0] w_res;

  assign w_res      = next_count(32'(i_count), STEP, MAX_VAL, i_up, SATURATE == MODE_SAT);
  assign o_next     = w_res[WIDTH-1:0];
  assign o_boundary = w_res[32];

  // Results are always <= MAX_VAL, so the bits above WIDTH are structurally zero.
  if (WIDTH < 32) begin : g_hi
    logic w_unused_hi;
    assign w_unused_hi = ^w_res[31:WIDTH];
  end

endmodule

// File: rtl/param_mod_counter.sv
// Parametrised modulus counter: wrap/saturate, up/down, synchronous clear and
// load, registered terminal-count pulse and sticky boundary flag.
module param_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter logic [31:0] MAX_VAL   = 32'((33'd1 << WIDTH) - 33'd1),
  parameter logic [31:0] STEP      = 32'd1,
  parameter logic        SATURATE  = MODE_WRAP,
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             wrap_flag
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("param_mod_counter: WIDTH must be 2..32");
  end
  if (MAX_VAL < 32'd1 || {1'b0, MAX_VAL} > ((33'd1 << WIDTH) - 33'd1)) begin : g_bad_max
    $error("param_mod_counter: MAX_VAL must be 1..2^WIDTH-1");
  end
  if (STEP < 32'd1 || STEP > MAX_VAL) begin : g_bad_step
    $error("param_mod_counter: STEP must be 1..MAX_VAL");
  end
  if (RESET_VAL > MAX_VAL) begin : g_bad_rst
    $error("param_mod_counter: RESET_VAL must not exceed MAX_VAL");
  end

  localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_W = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next;
  logic             w_boundary;

  mod_step_calc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .STEP    (STEP),
    .SATURATE(SATURATE)
  ) u_step (
    .i_count   (r_count),
    .i_up      (up_dn),
    .o_next    (w_next),
    .o_boundary(w_boundary)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= RST_W;
      r_tc    <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (clr) begin
      r_count <= RST_W;
      r_tc    <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_count <= (load_val > MAX_W) ? MAX_W : load_val;
      r_tc    <= 1'b0;
    end else if (en) begin
      r_count <= w_next;
      r_tc    <= w_boundary;
      r_wrap  <= r_wrap | w_boundary;
    end else begin
      r_tc    <= 1'b0;
    end
  end

  assign count_out = r_count;
  assign tc        = r_tc;
  assign wrap_flag = r_wrap;

endmodule

// File: tb/tb_param_mod_counter.sv
// Scoreboard bench: three counter configurations share one stimulus stream; an
// arithmetic reference model queues expected outputs, a monitor compares them.
module tb_param_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] c0, c1, c2;
  logic       t0, t1, t2;
  logic       w0, w1, w2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_mod_counter #(.WIDTH(4), .MAX_VAL(32'd9), .STEP(32'd1), .SATURATE(1'b0), .RESET_VAL(32'd0))
  u_d0 (.clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count_out(c0), .tc(t0), .wrap_flag(w0));

  param_mod_counter #(.WIDTH(4), .MAX_VAL(32'd9), .STEP(32'd4), .SATURATE(1'b1), .RESET_VAL(32'd0))
  u_d1 (.clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count_out(c1), .tc(t1), .wrap_flag(w1));

  param_mod_counter #(.WIDTH(4), .MAX_VAL(32'd9), .STEP(32'd3), .SATURATE(1'b0), .RESET_VAL(32'd2))
  u_d2 (.clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count_out(c2), .tc(t2), .wrap_flag(w2));

  // Reference model configuration and state, one slot per DUT.
  int unsigned stp [3] = '{1, 4, 3};
  bit          sat [3] = '{0, 1, 0};
  int unsigned rv  [3] = '{0, 0, 2};
  int unsigned maxv = 9;
  int unsigned mc [3];
  bit          mw [3];

  logic [17:0] q[$];
  logic [17:0] mon_e;

  task automatic chk(input int d, input logic [5:0] e, input logic [5:0] a);
    checks++;
    if (a[5:2] !== e[5:2]) begin
      errors++;
      $display("FAIL d%0d count got %0d exp %0d at %0t", d, a[5:2], e[5:2], $time);
    end
    checks++;
    if (a[1] !== e[1]) begin
      errors++;
      $display("FAIL d%0d tc got %0b exp %0b at %0t", d, a[1], e[1], $time);
    end
    checks++;
    if (a[0] !== e[0]) begin
      errors++;
      $display("FAIL d%0d wrap_flag got %0b exp %0b at %0t", d, a[0], e[0], $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk(0, mon_e[5:0],   {c0, t0, w0});
      chk(1, mon_e[11:6],  {c1, t1, w1});
      chk(2, mon_e[17:12], {c2, t2, w2});
    end
  end

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_edge();
    logic [17:0] e;
    bit          tcv;
    int unsigned modv;
    modv = maxv + 1;
    for (int i = 0; i < 3; i++) begin
      tcv = 1'b0;
      if (!rst_n || clr) begin
        mc[i] = rv[i];
        mw[i] = 1'b0;
      end else if (load) begin
        mc[i] = (int'(load_val) > maxv) ? maxv : int'(load_val);
      end else if (en) begin
        if (up_dn) begin
          if (mc[i] + stp[i] > maxv) begin
            tcv   = 1'b1;
            mc[i] = sat[i] ? maxv : (mc[i] + stp[i]) % modv;
          end else begin
            mc[i] = mc[i] + stp[i];
          end
        end else begin
          if (mc[i] < stp[i]) begin
            tcv   = 1'b1;
            mc[i] = sat[i] ? 0 : (mc[i] + modv - stp[i]) % modv;
          end else begin
            mc[i] = mc[i] - stp[i];
          end
        end
        if (tcv) mw[i] = 1'b1;
      end
      e[i*6 +: 6] = {mc[i][3:0], tcv, mw[i]};
    end
    q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit e, input bit u, input bit c, input bit l,
                       input logic [3:0] lv);
    @(negedge clk);
    rst_n = r; en = e; up_dn = u; clr = c; load = l; load_val = lv;
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    // Reset, then count up 12 cycles (wraps 9 -> 0 on D0)
    drive(0, 0, 1, 0, 0, 4'd0);
    drive(0, 0, 1, 0, 0, 4'd0);
    repeat (12) drive(1, 1, 1, 0, 0, 4'd0);
    // Clear, then count down from reset value
    drive(1, 0, 1, 1, 0, 4'd0);
    repeat (12) drive(1, 1, 0, 0, 0, 4'd0);
    // Out-of-range load clamps, in-range load, step up then down
    drive(1, 0, 1, 0, 1, 4'd15);
    drive(1, 0, 1, 0, 1, 4'd8);
    drive(1, 1, 1, 0, 0, 4'd0);
    drive(1, 1, 0, 0, 0, 4'd0);
    drive(1, 0, 1, 0, 0, 4'd0);
    // Priority combinations
    drive(0, 1, 1, 1, 1, 4'd5);
    drive(1, 1, 1, 1, 1, 4'd5);
    drive(1, 1, 1, 0, 1, 4'd7);
    drive(1, 1, 1, 0, 1, 4'd0);
    // Run up to a boundary, then reset mid-run and resume
    repeat (16) drive(1, 1, 1, 0, 0, 4'd0);
    drive(1, 0, 1, 0, 1, 4'd6);
    drive(0, 1, 1, 0, 0, 4'd0);
    repeat (3) drive(1, 1, 1, 0, 0, 4'd0);
    // Saturate at upper limit with en held, then hold with en low
    repeat (4) drive(1, 1, 1, 0, 0, 4'd0);
    drive(1, 0, 1, 0, 0, 4'd0);
    // Randomised stimulus
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 40) != 0),
            ($urandom_range(0, 4) != 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 30) == 0),
            ($urandom_range(0, 15) == 0),
            4'($urandom_range(0, 15)));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
